// File: rtl/riscv_pkg.sv
// Shared RV32I decode helpers: opcode[6:2] constants and register-use predicates.
package riscv_pkg;

  localparam logic [4:0] R_TYPE     = 5'b01100;
  localparam logic [4:0] I_CAL      = 5'b00100;
  localparam logic [4:0] I_LOAD     = 5'b00000;
  localparam logic [4:0] S_TYPE     = 5'b01000;
  localparam logic [4:0] B_TYPE     = 5'b11000;
  localparam logic [4:0] LUI_TYPE   = 5'b01101;
  localparam logic [4:0] AUIPC_TYPE = 5'b00101;
  localparam logic [4:0] JAL_TYPE   = 5'b11011;
  localparam logic [4:0] JALR_TYPE  = 5'b11001;

  function automatic logic uses_rs1(input logic [4:0] op);
    case (op)
      R_TYPE, I_CAL, I_LOAD, S_TYPE, B_TYPE, JALR_TYPE: uses_rs1 = 1'b1;
      default:                                          uses_rs1 = 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [4:0] op);
    case (op)
      R_TYPE, S_TYPE, B_TYPE: uses_rs2 = 1'b1;
      default:                uses_rs2 = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/hazard_ld.sv
// Load-use detector: a valid load in X whose rd (non-x0) is read by the valid instruction in D.
module hazard_ld
  import riscv_pkg::*;
(
  input  logic [31:0] instD,
  input  logic [31:0] instX,
  input  logic        validD,
  input  logic        validX,
  output logic        stall_ld
);

  logic [4:0] op_d, rs1_d, rs2_d, rd_x;
  logic       load_x, hit1, hit2;
  logic       unused_bits;

  assign op_d  = instD[6:2];
  assign rs1_d = instD[19:15];
  assign rs2_d = instD[24:20];
  assign rd_x  = instX[11:7];

  assign load_x = validX && (instX[6:2] == I_LOAD) && (rd_x != 5'd0);
  assign hit1   = uses_rs1(op_d) && (rs1_d == rd_x);
  assign hit2   = uses_rs2(op_d) && (rs2_d == rd_x);

  assign stall_ld = load_x && validD && (hit1 || hit2);

  assign unused_bits = ^{instD[31:25], instD[14:7], instD[1:0], instX[31:12], instX[1:0]};

endmodule

// File: rtl/pipe_ctrl.sv
// 5-stage pipeline sequencer: valid bits, kills, load-use stall, memory wait states.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instD,
  input  logic [31:0] instX,
  input  logic        killD_req_next,
  input  logic        killX_req_next,
  input  logic        imem_ready,
  input  logic        dmem_busy,
  output logic        validF,
  output logic        validD,
  output logic        validX,
  output logic        validM,
  output logic        validW,
  output logic        pc_en,
  output logic        enD,
  output logic        enX,
  output logic        enM,
  output logic        enW,
  output logic        stall_ld
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_kill_cnt,
  output logic [CNT_W-1:0] perf_freeze_cnt
`endif
);

  logic pend_d, pend_x;
  logic freeze, kill_d, kill_x, kill, stall;

  hazard_ld u_hazard (
    .instD    (instD),
    .instX    (instX),
    .validD   (validD),
    .validX   (validX),
    .stall_ld (stall_ld)
  );

  // Kills requested during a freeze are parked in pend_* and replayed on release.
  assign freeze = dmem_busy;
  assign kill_d = killD_req_next | pend_d;
  assign kill_x = killX_req_next | pend_x;
  assign kill   = kill_d | kill_x;
  assign stall  = stall_ld & ~kill;

  always_comb begin
    pc_en = 1'b0;
    enD   = 1'b0;
    enX   = 1'b0;
    enM   = 1'b0;
    enW   = 1'b0;
    if (!rst) begin
      if (freeze) begin
        enW = 1'b1;
      end else begin
        pc_en = kill | (~stall & imem_ready);
        enD   = ~stall;
        enX   = 1'b1;
        enM   = 1'b1;
        enW   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      validF <= 1'b0;
      validD <= 1'b0;
      validX <= 1'b0;
      validM <= 1'b0;
      validW <= 1'b0;
      pend_d <= 1'b0;
      pend_x <= 1'b0;
    end else if (freeze) begin
      validW <= 1'b0;
      pend_d <= pend_d | killD_req_next;
      pend_x <= pend_x | killX_req_next;
    end else begin
      validF <= 1'b1;
      // An instruction fetched while imem is not ready is never valid.
      validD <= stall ? validD : (validF & imem_ready & ~kill_d);
      validX <= validD & ~stall & ~kill_x;
      validM <= validX;
      validW <= validM;
      pend_d <= 1'b0;
      pend_x <= 1'b0;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt  <= '0;
      perf_kill_cnt   <= '0;
      perf_freeze_cnt <= '0;
    end else begin
      if (!freeze && stall && perf_stall_cnt != '1)
        perf_stall_cnt <= perf_stall_cnt + 1'b1;
      if (!freeze && kill && perf_kill_cnt != '1)
        perf_kill_cnt <= perf_kill_cnt + 1'b1;
      if (freeze && perf_freeze_cnt != '1)
        perf_freeze_cnt <= perf_freeze_cnt + 1'b1;
    end
  end
`else
  localparam int UNUSED_CNT_W = CNT_W;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed per-cycle vector bench for pipe_ctrl; valids checked before each edge.
module tb_pipe_ctrl;

  logic        clk, rst;
  logic [31:0] instD, instX;
  logic        killD_req_next, killX_req_next, imem_ready, dmem_busy;
  logic        validF, validD, validX, validM, validW;
  logic        pc_en, enD, enX, enM, enW, stall_ld;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt, perf_kill_cnt, perf_freeze_cnt;
`endif

  pipe_ctrl #(.CNT_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .instD          (instD),
    .instX          (instX),
    .killD_req_next (killD_req_next),
    .killX_req_next (killX_req_next),
    .imem_ready     (imem_ready),
    .dmem_busy      (dmem_busy),
    .validF         (validF),
    .validD         (validD),
    .validX         (validX),
    .validM         (validM),
    .validW         (validW),
    .pc_en          (pc_en),
    .enD            (enD),
    .enX            (enX),
    .enM            (enM),
    .enW            (enW),
    .stall_ld       (stall_ld)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_kill_cnt  (perf_kill_cnt),
    .perf_freeze_cnt(perf_freeze_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  localparam logic [31:0] NOP   = 32'h0000_0013; // addi x0,x0,0
  localparam logic [31:0] LW5   = 32'h0000_A283; // lw x5,0(x1)
  localparam logic [31:0] ADD   = 32'h0022_8333; // add x6,x5,x2
  localparam logic [31:0] LW0   = 32'h0000_A003; // lw x0,0(x1)
  localparam logic [31:0] ADDX0 = 32'h0020_0333; // add x6,x0,x2
  localparam logic [31:0] ADDR2 = 32'h0051_0333; // add x6,x2,x5
  localparam logic [31:0] LUI   = 32'h0002_83B7; // lui x7 (rs1 field bits = 5)

  typedef struct {
    logic        rst, kd, kx, imr, busy;
    logic [31:0] d, x;
    logic [4:0]  v;   // {F,D,X,M,W}
    logic [4:0]  en;  // {pc_en,enD,enX,enM,enW}
    logic        s;
  } vec_t;

  localparam int NV = 38;
  vec_t tbl [NV];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(input logic r, kd, kx, imr, busy,
                              input logic [31:0] d, x,
                              input logic [4:0] v, en, input logic s);
    vec_t t;
    t.rst = r; t.kd = kd; t.kx = kx; t.imr = imr; t.busy = busy;
    t.d = d; t.x = x; t.v = v; t.en = en; t.s = s;
    return t;
  endfunction

  task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got v=%b en=%b s=%b, want v=%b en=%b s=%b",
               name, got[10:6], got[5:1], got[0], exp[10:6], exp[5:1], exp[0]);
    end
  endtask

  function automatic logic [10:0] outs();
    return {validF, validD, validX, validM, validW, pc_en, enD, enX, enM, enW, stall_ld};
  endfunction

  initial begin
    //            rst kd kx imr bsy  D      X      v         en        s
    tbl[0]  = mk(1, 0, 0, 1, 0, NOP,   NOP, 5'b00000, 5'b00000, 0);
    tbl[1]  = mk(1, 0, 0, 1, 0, NOP,   NOP, 5'b00000, 5'b00000, 0);
    tbl[2]  = mk(1, 0, 0, 1, 0, NOP,   NOP, 5'b00000, 5'b00000, 0);
    tbl[3]  = mk(0, 0, 0, 1, 0, NOP,   NOP, 5'b00000, 5'b11111, 0);
    tbl[4]  = mk(0, 0, 0, 1, 0, NOP,   NOP, 5'b10000, 5'b11111, 0);
    tbl[5]  = mk(0, 0, 0, 1, 0, NOP,   NOP, 5'b11000, 5'b11111, 0);
    tbl[6]  = mk(0, 0, 0, 1, 0, NOP,   NOP, 5'b11100, 5'b11111, 0);
    tbl[7]  = mk(0, 0, 0, 1, 0, NOP,   NOP, 5'b11110, 5'b11111, 0);
    tbl[8]  = mk(0, 0, 0, 1, 0, ADD,   LW5, 5'b11111, 5'b00111, 1);
    tbl[9]  = mk(0, 0, 0, 1, 0, ADD,   LW5, 5'b11011, 5'b11111, 0);
    tbl[10] = mk(0, 0, 0, 1, 0, ADDX0, LW0, 5'b11101, 5'b11111, 0);
    tbl[11] = mk(0, 0, 0, 1, 0, ADDR2, LW5, 5'b11110, 5'b00111, 1);
    tbl[12] = mk(0, 0, 0, 1, 0, NOP,   NOP, 5'b11011, 5'b11111, 0);
    tbl[13] = mk(0, 0, 0, 1, 0, LUI,   LW5, 5'b11101, 5'b11111, 0);
    tbl[14] = mk(0, 1, 1, 1, 0, NOP,   NOP, 5'b11110, 5'b11111, 0);
    tbl[15] = mk(0, 0, 0, 1, 0, NOP,   NOP, 5'b10011, 5'b11111, 0);
    tbl[16] = mk(0, 0, 0, 1, 0, NOP,   NOP, 5'b11001, 5'b11111, 0);
    tbl[17] = mk(0, 1, 1, 1, 0, ADD,   LW5, 5'b11100, 5'b11111, 1);
    tbl[18] = mk(0, 0, 0, 1, 0, NOP,   NOP, 5'b10010, 5'b11111, 0);
    tbl[19] = mk(0, 0, 0, 1, 0, NOP,   NOP, 5'b11001, 5'b11111, 0);
    tbl[20] = mk(0, 0, 0, 1, 0, NOP,   NOP, 5'b11100, 5'b11111, 0);
    tbl[21] = mk(0, 0, 0, 1, 0, NOP,   NOP, 5'b11110, 5'b11111, 0);
    tbl[22] = mk(0, 0, 0, 1, 1, NOP,   NOP, 5'b11111, 5'b00001, 0);
    tbl[23] = mk(0, 1, 0, 1, 1, NOP,   NOP, 5'b11110, 5'b00001, 0);
    tbl[24] = mk(0, 0, 0, 1, 1, NOP,   NOP, 5'b11110, 5'b00001, 0);
    tbl[25] = mk(0, 0, 0, 1, 1, NOP,   NOP, 5'b11110, 5'b00001, 0);
    tbl[26] = mk(0, 0, 0, 1, 0, NOP,   NOP, 5'b11110, 5'b11111, 0);
    tbl[27] = mk(0, 0, 0, 1, 0, NOP,   NOP, 5'b10111, 5'b11111, 0);
    tbl[28] = mk(0, 0, 0, 0, 0, NOP,   NOP, 5'b11011, 5'b01111, 0);
    tbl[29] = mk(0, 0, 0, 0, 0, NOP,   NOP, 5'b10101, 5'b01111, 0);
    tbl[30] = mk(0, 0, 0, 1, 0, NOP,   NOP, 5'b10010, 5'b11111, 0);
    tbl[31] = mk(0, 0, 0, 1, 0, NOP,   NOP, 5'b11001, 5'b11111, 0);
    tbl[32] = mk(0, 0, 0, 1, 0, NOP,   NOP, 5'b11100, 5'b11111, 0);
    tbl[33] = mk(0, 0, 1, 1, 1, NOP,   NOP, 5'b11110, 5'b00001, 0);
    tbl[34] = mk(1, 0, 0, 1, 1, NOP,   NOP, 5'b11110, 5'b00000, 0);
    tbl[35] = mk(0, 0, 0, 1, 0, NOP,   NOP, 5'b00000, 5'b11111, 0);
    tbl[36] = mk(0, 0, 0, 1, 0, NOP,   NOP, 5'b10000, 5'b11111, 0);
    tbl[37] = mk(0, 0, 0, 1, 0, NOP,   NOP, 5'b11000, 5'b11111, 0);

    rst = 1'b1; instD = NOP; instX = NOP;
    killD_req_next = 1'b0; killX_req_next = 1'b0;
    imem_ready = 1'b1; dmem_busy = 1'b0;
    @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst = tbl[i].rst; killD_req_next = tbl[i].kd; killX_req_next = tbl[i].kx;
      imem_ready = tbl[i].imr; dmem_busy = tbl[i].busy;
      instD = tbl[i].d; instX = tbl[i].x;
      #2;
      check($sformatf("vec%0d", i), outs(), {tbl[i].v, tbl[i].en, tbl[i].s});
    end

    // Reset asserted while a load-use stall is pending: enables drop, then all clears.
    @(negedge clk);
    rst = 1'b1; instD = ADD; instX = LW5;
    killD_req_next = 1'b0; killX_req_next = 1'b0; imem_ready = 1'b1; dmem_busy = 1'b0;
    #2;
    check("rst_mid_stall_en", outs(), {5'b11100, 5'b00000, 1'b1});
    @(negedge clk);
    #2;
    check("rst_mid_stall_clr", outs(), {5'b00000, 5'b00000, 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline sequencer for the 5-stage RV32I core (F, D, X, M, W).
- Owns the per-stage valid bits consumed by the branch unit.
- Applies that unit's kill requests, detects load-use hazards, handles instruction/data memory wait states, and drives every pipeline-register enable plus the PC enable.
- Sits beside the datapath; one instance per core.

Parameters:
- CNT_W, 32, width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- instD  in  32  instruction in the D stage
- instX  in  32  instruction in the X stage
- killD_req_next  in  1  branch unit: invalidate the instruction moving F->D
- killX_req_next  in  1  branch unit: invalidate the instruction moving D->X
- imem_ready  in  1  fetch data valid this cycle
- dmem_busy  in  1  M-stage memory access not complete
- validF, validD, validX, validM, validW  out  1  per-stage valid (registered)
- pc_en  out  1  PC register load enable
- enD, enX, enM, enW  out  1  pipeline-register load enables (F->D, D->X, X->M, M->W)
- stall_ld  out  1  load-use stall active this cycle (combinational)

Behaviour:
- Reset (rst=1 at a clock edge):
  - all valid bits go to 0; pending-kill flags go to 0.
  - While rst=1, pc_en and all en* are 0.
  - validF goes to 1 on the first edge with rst=0; all other valids fill in from there.
- Priority, highest first: rst > freeze (dmem_busy) > kill > load-use stall > fetch bubble.
- Freeze (dmem_busy=1):
  - pc_en = enD = enX = enM = 0; valids F..M hold.
  - enW=1 and validW <= 0 (bubble into W).
- Kill (no freeze):
  - killD_req_next=1 -> validD <= 0 at the next edge.
  - killX_req_next=1 -> validX <= 0 at the next edge.
  - The instruction moving F->D/D->X is still loaded (enables high) but marked invalid.
  - pc_en=1, so the PC loads the redirect target.
- Pending kill:
  - A kill request arriving while frozen sets a sticky flag (pendD/pendX).
  - The flag is applied on the first non-frozen edge and then cleared.
  - A fresh request in the same cycle ORs with the flag.
- Load-use stall:
  - Condition: validX, instX[6:2]=I_LOAD (5'b00000), rdX=instX[11:7]!=0, validD, and instD uses rs1 (instD[19:15]) or rs2 (instD[24:20]) equal to rdX.
  - rs1 is used by R, I_CAL, I_LOAD, S, B, JALR; rs2 by R, S, B.
  - Response: pc_en=0, enD=0 (F, D hold); enX=1 with validX <= 0 (bubble); M, W advance.
  - A kill in the same cycle overrides the stall: the stall is dropped and the kill applied.
- Fetch bubble:
  - imem_ready=0 and no higher event -> pc_en=0, enD=1, validD <= 0.
  - Downstream stages advance normally.
- Normal advance: all enables 1; validD<=validF, validX<=validD, validM<=validX, validW<=validM.
- Latency: every stage is 1 cycle; kill takes effect at the next edge (no extra delay).
- rst asserted mid-stall or mid-freeze clears everything, including pending kills, on that edge.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- Defined:
  - outputs perf_stall_cnt[CNT_W-1:0] counts cycles with stall_ld=1 and no kill.
  - perf_kill_cnt[CNT_W-1:0] counts edges where a kill (including pending) is applied.
  - perf_freeze_cnt[CNT_W-1:0] counts dmem_busy cycles.
  - All three are reset to 0 by rst and saturate at all-ones.
- Not defined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package riscv_pkg: opcode[6:2] constants (R_TYPE, B_TYPE, I_CAL, I_LOAD, S_TYPE, LUI_TYPE, AUIPC_TYPE, JAL_TYPE, JALR_TYPE) and uses_rs1/uses_rs2 decode functions. The branch unit shares the same package.
- Sub-module hazard_ld: combinational load-use detector (instD, instX, validD, validX -> stall_ld).

Test Plan:
- Reset release:
  - rst=1 for 3 cycles then 0 with imem_ready=1 -> validF=1 at edge 1.
  - validD..validW rise on successive edges; all valids 0 during reset.
- Load-use:
  - instX=lw x5,0(x1), instD=add x6,x5,x2, both valid -> stall_ld=1, pc_en=0, enD=0.
  - Next cycle validX=0, instD unchanged; one-cycle stall only.
- Load to x0:
  - instX=lw x0, instD reads x0 -> stall_ld=0.
- JALR kill:
  - killD_req_next=killX_req_next=1 for one cycle -> next cycle validD=0, validX=0, validM carries the JALR.
- Kill during freeze:
  - dmem_busy=1 for 4 cycles with killD_req_next pulsed in cycle 2 -> valids hold and validW=0 during the freeze.
  - validD=0 on the first edge after dmem_busy falls.
- Fetch wait:
  - imem_ready=0 for 2 cycles -> pc_en=0; two bubbles (validD=0) propagate to W.
